// File: rtl/frame_buffer_writer.sv
// Write-side controller for the pixel frame buffer: turns a raster-order valid/ready
// pixel stream into registered linear RAM writes and reports row/frame progress.
module frame_buffer_writer #(
  parameter int unsigned ROW_SIZE = 66,
  parameter int unsigned NUM_ROWS = 130,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned DATA_W   = 8
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic              iHOLD,
  input  logic              iPX_VALID,
  input  logic [DATA_W-1:0] iPX_DATA,
  output logic              oPX_READY,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [DATA_W-1:0] oWR_DATA,
  output logic [7:0]        oROWS_DONE,
  output logic              oBUSY,
  output logic              oFRAME_DONE
);

  localparam int unsigned COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic [ROW_W-1:0]    row_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic [7:0]          rows_done_q;
  logic                frame_done_q;

  logic xfer_c;
  logic last_col_c;
  logic last_row_c;

  // Ready is a function of state and back-pressure only, never of iPX_VALID.
  assign oPX_READY  = (state_q == S_LOAD) && !iHOLD;
  assign xfer_c     = iPX_VALID && oPX_READY;
  assign last_col_c = (col_q == COL_W'(ROW_SIZE - 1));
  assign last_row_c = (row_q == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rows_done_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (iSTART) begin
            state_q     <= S_LOAD;
            col_q       <= '0;
            row_q       <= '0;
            addr_q      <= '0;
            rows_done_q <= '0;
          end
        end
        S_LOAD: begin
          if (xfer_c) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= iPX_DATA;
            addr_q    <= addr_q + ADDR_W'(1);
            // Column wrap closes a row; the last column of the last row ends the frame.
            if (last_col_c) begin
              col_q       <= '0;
              row_q       <= row_q + ROW_W'(1);
              rows_done_q <= rows_done_q + 8'd1;
              if (last_row_c) begin
                state_q      <= S_DONE;
                frame_done_q <= 1'b1;
              end
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign oWR_EN      = wr_en_q;
  assign oWR_ADDR    = wr_addr_q;
  assign oWR_DATA    = wr_data_q;
  assign oROWS_DONE  = rows_done_q;
  assign oFRAME_DONE = frame_done_q;
  assign oBUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Scoreboard bench for frame_buffer_writer: a reference model predicts every RAM write,
// which is queued with its due cycle and compared when the DUT presents it.
module tb_frame_buffer_writer;

  localparam int unsigned ROW_SIZE = 66;
  localparam int unsigned NUM_ROWS = 130;
  localparam int unsigned ADDR_W   = 14;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned LAST_ADDR = ROW_SIZE * NUM_ROWS - 1;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b0;
  logic              iSTART = 1'b0;
  logic              iHOLD = 1'b0;
  logic              iPX_VALID = 1'b0;
  logic [DATA_W-1:0] iPX_DATA = '0;
  logic              oPX_READY;
  logic              oWR_EN;
  logic [ADDR_W-1:0] oWR_ADDR;
  logic [DATA_W-1:0] oWR_DATA;
  logic [7:0]        oROWS_DONE;
  logic              oBUSY;
  logic              oFRAME_DONE;

  frame_buffer_writer #(
    .ROW_SIZE(ROW_SIZE), .NUM_ROWS(NUM_ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iHOLD(iHOLD),
    .iPX_VALID(iPX_VALID), .iPX_DATA(iPX_DATA), .oPX_READY(oPX_READY),
    .oWR_EN(oWR_EN), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
    .oROWS_DONE(oROWS_DONE), .oBUSY(oBUSY), .oFRAME_DONE(oFRAME_DONE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int          due;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [7:0]  rows;
    logic        fd;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   cyc = 0;

  // Model state: 0 idle, 1 load, 2 done
  int   m_state = 0;
  int   m_addr  = 0;
  int   m_rows  = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One input cycle: drive after the edge, then check ready/busy and advance the model.
  task automatic step(input logic s, input logic v, input logic h,
                      input logic [7:0] d, output bit acc);
    exp_t e;
    @(posedge iCLK);
    #1;
    iSTART = s; iPX_VALID = v; iHOLD = h; iPX_DATA = d;
    #1;
    acc = 1'b0;
    check_eq("busy", 32'(oBUSY), 32'(m_state != 0));
    check_eq("ready", 32'(oPX_READY), 32'(m_state == 1 && !h));
    case (m_state)
      0: if (s) begin m_state = 1; m_addr = 0; m_rows = 0; end
      1: if (v && !h) begin
        acc = 1'b1;
        if ((m_addr + 1) % ROW_SIZE == 0) m_rows++;
        e.due  = cyc + 1;
        e.addr = 14'(m_addr);
        e.data = d;
        e.rows = 8'(m_rows);
        e.fd   = (m_addr == LAST_ADDR);
        exp_q.push_back(e);
        m_addr++;
        if (e.fd) m_state = 2;
      end
      default: m_state = 0;
    endcase
  endtask

  // Compare DUT writes against the queue on the falling edge.
  always @(negedge iCLK) begin
    if (!iRST) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("wr_en", 32'(oWR_EN), 32'd1);
        check_eq("wr_addr", 32'(oWR_ADDR), 32'(e.addr));
        check_eq("wr_data", 32'(oWR_DATA), 32'(e.data));
        check_eq("rows_done", 32'(oROWS_DONE), 32'(e.rows));
        check_eq("frame_done", 32'(oFRAME_DONE), 32'(e.fd));
      end else begin
        check_eq("spurious_wr", 32'(oWR_EN), 32'd0);
        check_eq("spurious_fd", 32'(oFRAME_DONE), 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wr_en"}, 32'(oWR_EN), 32'd0);
    check_eq({tag, "_wr_addr"}, 32'(oWR_ADDR), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(oWR_DATA), 32'd0);
    check_eq({tag, "_rows"}, 32'(oROWS_DONE), 32'd0);
    check_eq({tag, "_busy"}, 32'(oBUSY), 32'd0);
    check_eq({tag, "_fd"}, 32'(oFRAME_DONE), 32'd0);
    check_eq({tag, "_ready"}, 32'(oPX_READY), 32'd0);
  endtask

  // mode 0: no stalls, stray iSTART at pixel 1000; mode 1: random gaps plus a 5-cycle hold mid-row.
  task automatic run_frame(input int mode, input int stop_at);
    bit acc;
    int p = 0;
    int hold_left = 0;
    bit hold_done = 0;
    int guard = 0;
    logic s, v, h;
    logic [7:0] d;
    step(1'b1, 1'b0, 1'b0, 8'h00, acc);
    while (p < stop_at) begin
      s = 1'b0; v = 1'b1; h = 1'b0;
      if (mode == 1) begin
        if (p == 300 && !hold_done) begin hold_left = 5; hold_done = 1; end
        if (hold_left > 0) begin
          h = 1'b1; hold_left--;
        end else begin
          v = ($urandom_range(3) != 0);
          h = ($urandom_range(7) == 0);
        end
        d = 8'(p) ^ 8'h5A;
      end else begin
        s = (p == 1000);
        d = 8'(p);
      end
      step(s, v, h, d, acc);
      if (acc) p++;
      guard++;
      if (guard > 40000) begin
        check_eq("frame_timeout", 32'(p), 32'(stop_at));
        break;
      end
    end
  endtask

  initial begin
    bit acc;
    #2 iRST = 1'b1;
    #1 check_all_zero("por");
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    step(1'b0, 1'b1, 1'b0, 8'hAA, acc);
    step(1'b0, 1'b1, 1'b0, 8'hAA, acc);

    run_frame(0, ROW_SIZE * NUM_ROWS);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, acc);
    check_eq("rows_hold_idle", 32'(oROWS_DONE), 32'(NUM_ROWS));

    run_frame(1, ROW_SIZE * NUM_ROWS);
    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00, acc);

    run_frame(0, 500);
    #1 iRST = 1'b1;
    #1 check_all_zero("midrst");
    exp_q.delete();
    m_state = 0;
    @(posedge iCLK);
    #1 iRST = 1'b0;

    run_frame(0, 70);
    repeat (4) step(1'b0, 1'b0, 1'b0, 8'h00, acc);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
# frame_buffer_writer

Write-side controller for the pixel frame buffer that the cell address decoder reads from. It accepts a raster-order pixel stream over a valid/ready handshake and produces one registered RAM write per accepted pixel. Write addresses are linear, row-major, with 66 pixels per row. It also reports frame progress (completed rows, frame done) so downstream cell/HOG logic can start decoding 10×10 cells once enough rows are resident.

## Interface
Parameters:
- ROW_SIZE, 66: pixels per buffered row (64 px plus 1-px border each side).
- NUM_ROWS, 130: rows per frame (128 plus border).
- ADDR_W, 14: RAM address width; ROW_SIZE*NUM_ROWS must be ≤ 2^ADDR_W.
- DATA_W, 8: pixel width.

Ports:
- iCLK  in  1  sole clock; all state updates on its rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iSTART  in  1  single-cycle request to begin loading a frame; honoured only in IDLE.
- iHOLD  in  1  downstream back-pressure; while high, no pixel is accepted.
- iPX_VALID  in  1  pixel on iPX_DATA is valid.
- iPX_DATA  in  DATA_W  pixel value.
- oPX_READY  out  1  block can accept a pixel this cycle.
- oWR_EN  out  1  RAM write strobe (registered).
- oWR_ADDR  out  ADDR_W  RAM write address (registered).
- oWR_DATA  out  DATA_W  RAM write data (registered).
- oROWS_DONE  out  8  number of rows fully written in the current frame.
- oBUSY  out  1  high whenever the state is not IDLE.
- oFRAME_DONE  out  1  one-cycle pulse coincident with the final write of a frame.

## Operation
- FSM states are IDLE, LOAD and DONE.
- **IDLE**
  - oPX_READY = 0.
  - When iSTART = 1, go to LOAD and clear the column counter, row counter, address counter and oROWS_DONE.
- **LOAD**
  - oPX_READY = !iHOLD (combinational).
  - A transfer occurs when iPX_VALID && oPX_READY.
  - On each transfer:
    - Register oWR_EN=1, oWR_ADDR = address counter, oWR_DATA = iPX_DATA.
    - Increment the address counter.
    - Increment the column counter; on col = ROW_SIZE-1, wrap the column to 0, increment the row counter and increment oROWS_DONE.
  - Cycles with no transfer register oWR_EN=0. oWR_ADDR and oWR_DATA hold their last values.
  - The transfer at row NUM_ROWS-1, col ROW_SIZE-1 is the last pixel; the FSM then goes to DONE.
- **DONE** lasts exactly one cycle.
  - The registered last write is presented in this cycle (oWR_EN=1, oWR_ADDR=8579 with the defaults) together with oFRAME_DONE=1.
  - oPX_READY = 0.
  - Next state is IDLE.
- The address counter is maintained incrementally. No multiplier is used. Address always equals row*ROW_SIZE+col.
- iSTART in LOAD or DONE is ignored; a frame is never restarted mid-load.
- oROWS_DONE holds its final value (NUM_ROWS) in IDLE until the next accepted iSTART clears it.
- Reset at any point, including mid-frame, forces IDLE. All outputs and counters go to 0: oWR_EN, oWR_ADDR, oWR_DATA, oROWS_DONE, oBUSY, oFRAME_DONE, oPX_READY. Partially written RAM content is not cleaned up.

## Timing
- Latency is 1 cycle from transfer edge to oWR_EN/oWR_ADDR/oWR_DATA valid.
- Throughput is one pixel per cycle while iPX_VALID=1 and iHOLD=0. Full frame minimum is 8580 LOAD cycles plus 1 DONE cycle.
- oPX_READY depends on iHOLD combinationally. No combinational path exists from iPX_VALID to oPX_READY.
- oROWS_DONE updates on the same edge as the registered write of each row's last pixel, so it is visible in the cycle that write is presented.
- oBUSY rises the cycle after the accepted iSTART and falls the cycle after DONE.
- iHOLD rising in the same cycle as iPX_VALID means no transfer; the pixel must be held by the source.

## Test plan
- **Reset values:** assert iRST mid-cycle → all outputs 0 immediately (asynchronous); after release, state is IDLE and oPX_READY=0 regardless of iPX_VALID.
- **Full frame, no stalls:** iSTART, then 8580 consecutive valid pixels with data = addr[7:0] →
  - oWR_ADDR runs 0..8579 with no gaps; oWR_DATA matches.
  - oROWS_DONE steps 1..130 at addresses 65, 131, …, 8579.
  - oFRAME_DONE is high only with addr 8579; oBUSY falls one cycle later.
- **Row wrap:** after 66 transfers → write #66 at addr 65, write #67 at addr 66, oROWS_DONE=1.
- **Back-pressure:** iHOLD=1 for 5 cycles mid-row with iPX_VALID=1 →
  - oPX_READY=0 and oWR_EN=0 for those cycles.
  - The address resumes at the next value with no skip or duplicate.
- **Ignored start:** pulse iSTART at pixel 1000 of LOAD → counters unaffected; frame completes at addr 8579.
- **Reset mid-frame:** reset after 500 pixels, then iSTART → first write at addr 0, oROWS_DONE=0.
